// File: rtl/seq_pkg.sv
// Shared types and constants for the sequence pattern generator.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] SYM_00 = 2'b00;
    localparam logic [1:0] SYM_01 = 2'b01;
    localparam logic [1:0] SYM_10 = 2'b10;
    localparam logic [1:0] SYM_11 = 2'b11;

    // Index width for a buffer of d entries, never narrower than one bit.
    function automatic int addr_w(input int d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

endpackage

// File: rtl/seq_pattern_gen_if.sv
// Buffer-write, start control and symbol output bundle of seq_pattern_gen.
interface seq_pattern_gen_if
    import seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
);
    localparam int AW = addr_w(DEPTH);

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [1:0]       wr_sym;
    logic [AW:0]      len;
    logic [CNT_W-1:0] hold;
    logic             start;
    logic             x1;
    logic             x2;
    logic             sym_valid;
    logic             busy;
    logic             done;

    modport master (
        output wr_en, wr_addr, wr_sym, len, hold, start,
        input  x1, x2, sym_valid, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_sym, len, hold, start,
        output x1, x2, sym_valid, busy, done
    );

endinterface

// File: rtl/seq_sym_buf.sv
// DEPTH x 2 symbol register file: one write port, one async read port, async clear.
module seq_sym_buf
    import seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [1:0]    wr_sym,
    input  logic [AW-1:0] rd_addr,
    output logic [1:0]    rd_sym
);

    logic [1:0] mem [DEPTH];

    // Out-of-range indices only exist when DEPTH is not a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= SYM_00;
            end
        end else if (we && (int'(wr_addr) < DEPTH)) begin
            mem[wr_addr] <= wr_sym;
        end
    end

    assign rd_sym = (int'(rd_addr) < DEPTH) ? mem[rd_addr] : SYM_00;

endmodule

// File: rtl/seq_pattern_gen.sv
// Plays a buffered list of 2-bit symbols onto x1/x2, each held hold+1 cycles.
module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input logic              clk,
    input logic              rst,
    seq_pattern_gen_if.slave bus
);

    localparam int AW = addr_w(DEPTH);
    localparam int LW = AW + 1;

    state_t           state;
    logic [AW-1:0]    idx;
    logic [AW-1:0]    rd_addr;
    logic [LW-1:0]    len_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hold_q;
    logic [1:0]       rd_sym;
    logic [1:0]       first_sym;
    logic [1:0]       sym_q;
    logic             buf_we;
    logic             start_ok;
    logic             last_sym;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;

    assign buf_we   = bus.wr_en && (state == IDLE);
    assign start_ok = bus.start && (state == IDLE) && (bus.len != '0);
    assign rd_addr  = (state == IDLE) ? '0 : idx + AW'(1);
    assign last_sym = ({1'b0, idx} == len_q - LW'(1));
    // A same-cycle write to entry 0 must be the first symbol sent.
    assign first_sym = (buf_we && (bus.wr_addr == '0)) ? bus.wr_sym : rd_sym;

    seq_sym_buf #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .we      (buf_we),
        .wr_addr (bus.wr_addr),
        .wr_sym  (bus.wr_sym),
        .rd_addr (rd_addr),
        .rd_sym  (rd_sym)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            cnt     <= '0;
            len_q   <= '0;
            hold_q  <= '0;
            sym_q   <= SYM_00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_ok) begin
                        state   <= SEND;
                        len_q   <= (bus.len > LW'(DEPTH)) ? LW'(DEPTH) : bus.len;
                        hold_q  <= bus.hold;
                        idx     <= '0;
                        cnt     <= bus.hold;
                        sym_q   <= first_sym;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                SEND: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (!last_sym) begin
                        idx   <= idx + AW'(1);
                        cnt   <= hold_q;
                        sym_q <= rd_sym;
                    end else begin
                        state   <= DONE;
                        sym_q   <= SYM_00;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    idx    <= '0;
                    cnt    <= '0;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.x1        = sym_q[1];
    assign bus.x2        = sym_q[0];
    assign bus.sym_valid = valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule
